bcd_display_driver: RTL and testbench

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 31 +++
 rtl/bcd_display_driver.sv | 115 +++++++++++
 tb/tb_bcd_display_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: digit width, blank code and
// the active-high 7-segment patterns (bit0 = a .. bit6 = g).
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage : bcd_pkg

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder with active-low outputs.
// Any code outside 0..9 (including the blank code) lights nothing.
module seg7_decoder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] code_i,
  output logic [6:0]         seg_n_o
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = SEG_BLANK;
    unique case (code_i)
      4'd0:    seg_hi = SEG_0;
      4'd1:    seg_hi = SEG_1;
      4'd2:    seg_hi = SEG_2;
      4'd3:    seg_hi = SEG_3;
      4'd4:    seg_hi = SEG_4;
      4'd5:    seg_hi = SEG_5;
      4'd6:    seg_hi = SEG_6;
      4'd7:    seg_hi = SEG_7;
      4'd8:    seg_hi = SEG_8;
      4'd9:    seg_hi = SEG_9;
      default: seg_hi = SEG_BLANK;
    endcase
  end

  assign seg_n_o = ~seg_hi;

endmodule : seg7_decoder

// File: rtl/bcd_display_driver.sv
// Keypad digit buffer with a multiplexed 7-segment scan. New digits shift in
// at position 0 (rightmost); the scan lights one position per SCAN_DIV clocks.
module bcd_display_driver
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGIT_W-1:0]    bcd,
  input  logic                  valid_data,
  input  logic                  clear,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [3:0]            digit_count,
  output logic                  full
);

  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);

  logic [DIGIT_W-1:0]    buf_q [NUM_DIGITS];
  logic [DIGIT_W-1:0]    buf_d [NUM_DIGITS];
  logic [3:0]            count_q, count_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]            seg_n_q;
  logic [6:0]            seg_n_dec;
  logic [DIGIT_W-1:0]    digit_sel;
  logic                  full_w;
  logic                  accept;

  assign full_w = (count_q == 4'(NUM_DIGITS));
  assign accept = valid_data && (bcd <= 4'd9) && !full_w && !clear;

  // Clear takes priority over a same-cycle strobe.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_d[i] = BLANK;
      end
      count_d = 4'd0;
    end else if (accept) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        buf_d[i] = buf_q[i-1];
      end
      buf_d[0] = bcd;
      count_d  = count_q + 4'd1;
    end
  end

  always_comb begin
    div_d  = div_q + 1'b1;
    scan_d = scan_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d  = '0;
      scan_d = (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

  always_comb begin
    digit_sel = BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        digit_sel = buf_q[i];
      end
    end
  end

  assign an_n_d = ~(NUM_DIGITS'(1) << scan_q);

  seg7_decoder u_seg7_decoder (
    .code_i  (digit_sel),
    .seg_n_o (seg_n_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= BLANK;
      end
      count_q <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= buf_d[i];
      end
      count_q <= count_d;
    end
  end

  // Anode and segment registers update together so no other anode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      scan_q  <= '0;
      an_n_q  <= '1;
      seg_n_q <= 7'h7F;
    end else begin
      div_q   <= div_d;
      scan_q  <= scan_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_dec;
    end
  end

  assign seg_n       = seg_n_q;
  assign an_n        = an_n_q;
  assign digit_count = count_q;
  assign full        = full_w;

endmodule : bcd_display_driver

// File: tb/tb_bcd_display_driver.sv
// Randomised and directed bench for bcd_display_driver with a cycle-level
// behavioural model (digit list + edge counter) checked every clock.
module tb_bcd_display_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    bcd = 4'd0;
  logic          valid_data = 1'b0;
  logic          clear = 1'b0;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [3:0]    digit_count;
  logic          full;

  int tests = 0;
  int fails = 0;

  bcd_display_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bcd         (bcd),
    .valid_data  (valid_data),
    .clear       (clear),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digit_count (digit_count),
    .full        (full)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Behavioural model: stored digits, count, and edges seen since reset.
  int            m_buf [ND];
  int            m_count = 0;
  int            m_edges = 0;
  logic [ND-1:0] exp_an  = '1;
  logic [6:0]    exp_seg = 7'h7F;

  function automatic logic [6:0] seg_of(int code);
    logic [6:0] hi;
    case (code)
      0: hi = 7'h3F; 1: hi = 7'h06; 2: hi = 7'h5B; 3: hi = 7'h4F;
      4: hi = 7'h66; 5: hi = 7'h6D; 6: hi = 7'h7D; 7: hi = 7'h07;
      8: hi = 7'h7F; 9: hi = 7'h6F;
      default: hi = 7'h00;
    endcase
    return ~hi;
  endfunction

  initial for (int i = 0; i < ND; i++) m_buf[i] = 15;

  always @(posedge clk or negedge rst_n) begin
    int idx;
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) m_buf[i] = 15;
      m_count = 0;
      m_edges = 0;
      exp_an  = '1;
      exp_seg = 7'h7F;
    end else begin
      idx     = (m_edges / SD) % ND;
      exp_an  = ~(ND'(1) << idx);
      exp_seg = seg_of(m_buf[idx]);
      if (clear) begin
        for (int i = 0; i < ND; i++) m_buf[i] = 15;
        m_count = 0;
      end else if (valid_data && bcd <= 4'd9 && m_count < ND) begin
        for (int i = ND - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = int'(bcd);
        m_count++;
      end
      m_edges++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model an_n", 32'(an_n), 32'(exp_an));
    chk("model seg_n", 32'(seg_n), 32'(exp_seg));
    chk("model digit_count", 32'(digit_count), 32'(m_count));
    chk("model full", 32'(full), 32'(m_count == ND));
  end

  task automatic wait_an(input logic [ND-1:0] target);
    int n = 0;
    @(negedge clk);
    while (an_n !== target && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (an_n !== target) begin
      tests++;
      fails++;
      $display("FAIL wait_an: actual %b required %b (timeout)", an_n, target);
    end
  endtask

  task automatic strobe(input logic [3:0] d);
    @(posedge clk); #1;
    bcd = d; valid_data = 1'b1;
    @(posedge clk); #1;
    valid_data = 1'b0;
    $display("[TB] strobe bcd=%0h count=%0d full=%0b", d, digit_count, full);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    $display("[TB] clear count=%0d", digit_count);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset an_n", 32'(an_n), 32'hF);
    chk("reset seg_n", 32'(seg_n), 32'h7F);
    chk("reset count", 32'(digit_count), 32'd0);
    chk("reset full", 32'(full), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first an_n", 32'(an_n), 32'b1110);
    chk("first seg_n", 32'(seg_n), 32'h7F);
    repeat (4) @(negedge clk);
    chk("scan bit1", 32'(an_n), 32'b1101);
    repeat (4) @(negedge clk);
    chk("scan bit2", 32'(an_n), 32'b1011);
    repeat (4) @(negedge clk);
    chk("scan bit3", 32'(an_n), 32'b0111);
    chk("idle seg_n", 32'(seg_n), 32'h7F);
    repeat (4) @(negedge clk);
    chk("scan wrap", 32'(an_n), 32'b1110);

    strobe(4'd1); strobe(4'd2); strobe(4'd3);
    @(negedge clk);
    chk("count 123", 32'(digit_count), 32'd3);
    wait_an(4'b1110); chk("123 bit0", 32'(seg_n), 32'h30);
    wait_an(4'b1101); chk("123 bit1", 32'(seg_n), 32'h24);
    wait_an(4'b1011); chk("123 bit2", 32'(seg_n), 32'h79);
    wait_an(4'b0111); chk("123 bit3", 32'(seg_n), 32'h7F);

    do_clear();
    strobe(4'd5); strobe(4'd6); strobe(4'd7); strobe(4'd8);
    @(negedge clk);
    chk("full after 4", 32'(full), 32'd1);
    strobe(4'd9);
    @(negedge clk);
    chk("drop 9 count", 32'(digit_count), 32'd4);
    chk("drop 9 full", 32'(full), 32'd1);
    wait_an(4'b1110); chk("5678 bit0", 32'(seg_n), 32'h00);
    wait_an(4'b1101); chk("5678 bit1", 32'(seg_n), 32'h78);
    wait_an(4'b1011); chk("5678 bit2", 32'(seg_n), 32'h02);
    wait_an(4'b0111); chk("5678 bit3", 32'(seg_n), 32'h12);

    do_clear();
    strobe(4'd1);
    strobe(4'hA);
    @(negedge clk);
    chk("ignore A count", 32'(digit_count), 32'd1);
    wait_an(4'b1110); chk("ignore A bit0", 32'(seg_n), 32'h79);

    strobe(4'd2);
    @(posedge clk); #1;
    clear = 1'b1; valid_data = 1'b1; bcd = 4'd4;
    @(posedge clk); #1;
    clear = 1'b0; valid_data = 1'b0;
    $display("[TB] clear+strobe bcd=4 count=%0d", digit_count);
    @(negedge clk);
    chk("clear wins count", 32'(digit_count), 32'd0);
    wait_an(4'b1110); chk("clear wins bit0", 32'(seg_n), 32'h7F);
    wait_an(4'b1101); chk("clear wins bit1", 32'(seg_n), 32'h7F);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      valid_data = 1'($urandom_range(0, 1));
      bcd        = 4'($urandom_range(0, 15));
      clear      = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk); #1;
    valid_data = 1'b0; clear = 1'b0;

    strobe(4'd7); strobe(4'd3);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async an_n", 32'(an_n), 32'hF);
    chk("async seg_n", 32'(seg_n), 32'h7F);
    chk("async count", 32'(digit_count), 32'd0);
    chk("async full", 32'(full), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("restart bit0", 32'(an_n), 32'b1110);
    chk("restart seg", 32'(seg_n), 32'h7F);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_bcd_display_driver
